// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: the CPU memory port, the scanout read port and the single-port VRAM.
// Scanout handshake: vid_req is held with vid_addr stable until vid_ack; vid_ack is combinational and
// means the read was issued to the RAM this cycle. vid_rvalid/vid_rdata follow exactly one cycle later.
interface vram_arbiter_if;
  logic [15:0] cpu_address;
  logic        cpu_load;
  logic [15:0] cpu_wdata;
  logic        cpu_busy;
  logic [15:0] cpu_rdata;

  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic        vid_rvalid;
  logic [15:0] vid_rdata;

  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;

  // Arbiter state (1 = scanout owns the RAM) for checkers.
  logic        dbg_vid;

  modport slave (
    input  cpu_address, cpu_load, cpu_wdata, vid_req, vid_addr, ram_rdata,
    output cpu_busy, cpu_rdata, vid_ack, vid_rvalid, vid_rdata,
           ram_addr, ram_wdata, ram_we, dbg_vid
  );

  modport master (
    output cpu_address, cpu_load, cpu_wdata, vid_req, vid_addr, ram_rdata,
    input  cpu_busy, cpu_rdata, vid_ack, vid_rvalid, vid_rdata,
           ram_addr, ram_wdata, ram_we, dbg_vid
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-shares the single-port VRAM between the CPU and the scanout reader. cpu_busy comes straight
// from the state register so the RAM is never muxed away from the CPU within a busy-low cycle.
module vram_arbiter #(
  parameter int CPU_WINDOW    = 3,
  parameter int MAX_VID_BURST = 8
) (
  input logic           clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int WW = $clog2(CPU_WINDOW + 1);
  localparam int BW = $clog2(MAX_VID_BURST + 1);

  typedef enum logic {
    ST_CPU = 1'b0,
    ST_VID = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] win_cnt, win_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          ack;
  logic          vid_rvalid_q;
  logic          cpu_sel;
  logic          unused_addr_msb;

  assign cpu_sel         = bus.cpu_address[14] & ~bus.cpu_address[13];
  assign unused_addr_msb = bus.cpu_address[15];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_CPU;
      win_cnt      <= WW'(CPU_WINDOW);
      burst_cnt    <= '0;
      vid_rvalid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      win_cnt      <= win_nxt;
      burst_cnt    <= burst_nxt;
      vid_rvalid_q <= ack;
    end
  end

  always_comb begin
    state_nxt = state;
    win_nxt   = win_cnt;
    burst_nxt = burst_cnt;
    ack       = 1'b0;
    case (state)
      ST_CPU: begin
        if (win_cnt != WW'(CPU_WINDOW)) win_nxt = win_cnt + WW'(1);
        // The current busy-low cycle counts toward the window, hence the -1.
        if (bus.vid_req && (win_cnt >= WW'(CPU_WINDOW - 1))) begin
          state_nxt = ST_VID;
          burst_nxt = '0;
        end
      end
      ST_VID: begin
        ack = bus.vid_req;
        if (!bus.vid_req || (burst_cnt == BW'(MAX_VID_BURST - 1))) begin
          state_nxt = ST_CPU;
          win_nxt   = '0;
        end else begin
          burst_nxt = burst_cnt + BW'(1);
        end
      end
      default: state_nxt = ST_CPU;
    endcase
  end

  assign bus.cpu_busy   = (state == ST_VID);
  assign bus.dbg_vid    = (state == ST_VID);
  assign bus.ram_addr   = (state == ST_VID) ? bus.vid_addr : bus.cpu_address[12:0];
  assign bus.ram_wdata  = bus.cpu_wdata;
  assign bus.ram_we     = (state == ST_CPU) & bus.cpu_load & cpu_sel;
  assign bus.vid_ack    = ack;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.vid_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle registered 8K x 16 RAM model and a shadow copy
// of the expected RAM contents feeding the scanout data queue.
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vram_arbiter_if vif ();

  vram_arbiter #(
    .CPU_WINDOW   (3),
    .MAX_VID_BURST(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (vif.slave)
  );

  logic [15:0] mem    [8192];
  logic [15:0] shadow [8192];

  always @(posedge clk) begin
    if (vif.ram_we) mem[vif.ram_addr] <= vif.ram_wdata;
    vif.ram_rdata <= mem[vif.ram_addr];
  end

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic        prev_exp_ack;
  logic        prev_rd_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One arbiter cycle: check at the negedge, then step past the next posedge.
  task automatic cyc(input logic exp_busy, input logic exp_ack, input logic rd_win, input logic wr_chk);
    logic seen_ack;
    @(negedge clk);
    chk("cpu_busy", 32'(vif.cpu_busy), 32'(exp_busy));
    chk("vid_ack", 32'(vif.vid_ack), 32'(exp_ack));
    chk("vid_rvalid", 32'(vif.vid_rvalid), 32'(prev_exp_ack));
    if (prev_exp_ack && (exp_q.size() > 0)) chk("vid_rdata", 32'(vif.vid_rdata), 32'(exp_q.pop_front()));
    if (rd_win) begin
      chk("rd_ram_addr", 32'(vif.ram_addr), 32'h100);
      chk("rd_ram_we", 32'(vif.ram_we), 32'h0);
      if (prev_rd_win) chk("cpu_rdata", 32'(vif.cpu_rdata), 32'hBEEF);
    end
    if (wr_chk) begin
      chk("bnd_ram_we", 32'(vif.ram_we), 32'h1);
      chk("bnd_ram_addr", 32'(vif.ram_addr), 32'h200);
    end
    if (exp_ack) exp_q.push_back(shadow[vif.vid_addr]);
    prev_exp_ack = exp_ack;
    prev_rd_win  = rd_win;
    seen_ack     = vif.vid_ack;
    next_cycle();
    if (seen_ack) vif.vid_addr = vif.vid_addr + 13'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i]    = 16'(i * 37) ^ 16'hA5C3;
      shadow[i] = 16'(i * 37) ^ 16'hA5C3;
    end
    mem[13'h100]    = 16'hBEEF;
    shadow[13'h100] = 16'hBEEF;

    reset           = 1'b1;
    vif.cpu_address = 16'h0;
    vif.cpu_load    = 1'b0;
    vif.cpu_wdata   = 16'h0;
    vif.vid_req     = 1'b0;
    vif.vid_addr    = 13'h0;
    prev_exp_ack    = 1'b0;
    prev_rd_win     = 1'b0;

    // Reset, idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(vif.cpu_busy), 32'h0);
    chk("rst_rvalid", 32'(vif.vid_rvalid), 32'h0);
    chk("rst_ram_we", 32'(vif.ram_we), 32'h0);

    // VRAM write 0x4005
    next_cycle();
    vif.cpu_address = 16'h4005;
    vif.cpu_load    = 1'b1;
    vif.cpu_wdata   = 16'h1234;
    @(negedge clk);
    chk("wr_ram_we", 32'(vif.ram_we), 32'h1);
    chk("wr_ram_addr", 32'(vif.ram_addr), 32'h005);
    chk("wr_ram_wdata", 32'(vif.ram_wdata), 32'h1234);
    shadow[13'h005] = 16'h1234;

    // Non-VRAM writes and the top word of the window
    next_cycle();
    vif.cpu_address = 16'h2000;
    @(negedge clk);
    chk("nv2000_we", 32'(vif.ram_we), 32'h0);
    next_cycle();
    vif.cpu_address = 16'h6000;
    @(negedge clk);
    chk("nv6000_we", 32'(vif.ram_we), 32'h0);
    next_cycle();
    vif.cpu_address = 16'h5FFF;
    vif.cpu_wdata   = 16'hABCD;
    @(negedge clk);
    chk("top_we", 32'(vif.ram_we), 32'h1);
    chk("top_addr", 32'(vif.ram_addr), 32'h1FFF);
    shadow[13'h1FFF] = 16'hABCD;
    next_cycle();
    vif.cpu_address = 16'h8000;
    @(negedge clk);
    chk("nv8000_we", 32'(vif.ram_we), 32'h0);

    // Burst cap: 1 request cycle, 8 acks, 3 busy-low cycles, VID again
    next_cycle();
    vif.cpu_load    = 1'b0;
    vif.cpu_address = 16'h0;
    vif.vid_req     = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      cyc(((c >= 1) && (c <= 8)) || (c == 12), ((c >= 1) && (c <= 8)) || (c == 12), 1'b0, 1'b0);
    end
    vif.vid_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Short burst of 3 acks, then the window restarts
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    vif.vid_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    vif.vid_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    vif.vid_req = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // CPU write on the boundary cycle still happens
    vif.cpu_address = 16'h4200;
    vif.cpu_load    = 1'b1;
    vif.cpu_wdata   = 16'h7777;
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    shadow[13'h200] = 16'h7777;

    // CPU read of 0x4100 under continuous scanout
    vif.cpu_load    = 1'b0;
    vif.cpu_address = 16'h4100;
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // Reset during the 4th ack
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    reset        = 1'b0;
    prev_exp_ack = 1'b0;
    exp_q.delete();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    vif.vid_req = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Time-shares the single-port video RAM (8K x 16, word addresses 0x4000-0x5fff in CPU space) between the CPU and the display scanout reader. Drives the CPU's `mem_busy` input: while busy is high the scanout owns the RAM, and while it is low the CPU owns it. Guarantees the CPU a minimum ownership window so a VRAM read (busy low, then 2 wait cycles, then fetch) always completes. It also bounds scanout bursts so the CPU is never starved.

## Interface
Parameters:
- `CPU_WINDOW`, default 3: minimum consecutive cycles of busy low before scanout may take the RAM again.
- `MAX_VID_BURST`, default 8: maximum consecutive scanout accesses per ownership period.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `reset`  in  1: synchronous, active-high.
- `cpu_address`  in  16: CPU memory address.
- `cpu_load`  in  1: CPU write strobe.
- `cpu_wdata`  in  16: CPU write data.
- `cpu_busy`  out  1: to CPU `mem_busy`. Registered.
- `cpu_rdata`  out  16: equals `ram_rdata`, combinational passthrough.
- `vid_req`  in  1: scanout requests a read this cycle.
- `vid_addr`  in  13: scanout word address.
- `vid_ack`  out  1: scanout read issued this cycle. Combinational.
- `vid_rvalid`  out  1: `vid_rdata` valid, one cycle after `vid_ack`.
- `vid_rdata`  out  16: equals `ram_rdata`.
- `ram_addr`  out  13, `ram_wdata`  out  16, `ram_we`  out  1: RAM port.
- `ram_rdata`  in  16: RAM read data. Registered RAM, 1-cycle latency.

## Operation
- `cpu_sel = cpu_address[14] & ~cpu_address[13]`, i.e. the VRAM window.
- States:
  - CPU (busy low).
  - VID (busy high).
  - `cpu_busy` = (state == VID), taken directly from the state register.
- RAM port mux:
  - In VID: `ram_addr = vid_addr`, `ram_we = 0`.
  - In CPU: `ram_addr = cpu_address[12:0]`, `ram_wdata = cpu_wdata`, `ram_we = cpu_load & cpu_sel`.
- `vid_ack = (state == VID) & vid_req`.
- Counters:
  - `win_cnt` counts cycles spent in CPU and saturates at `CPU_WINDOW`.
  - `burst_cnt` counts acks in VID.
- CPU -> VID transition: when `vid_req` is high and `win_cnt >= CPU_WINDOW-1`, evaluated at the end of the cycle. Busy rises on the next edge. No ack is issued in the CPU state.
- VID -> CPU transition, when either of these holds at the end of a cycle:
  - `vid_req` is low, or
  - the ack in this cycle is the `MAX_VID_BURST`-th of the period.
- On entering CPU, `win_cnt` = 0. On entering VID, `burst_cnt` = 0.
- `vid_rvalid` is `vid_ack` delayed by one register.
- Reset values:
  - state = CPU, so `cpu_busy` = 0.
  - `win_cnt` = `CPU_WINDOW`, so the scanout may take the RAM immediately after reset.
  - `burst_cnt` = 0, `vid_rvalid` = 0.
- Reset mid-burst: VID is abandoned on the next edge. `vid_rvalid` is 0 in the cycle after reset, even if an ack was issued in the reset cycle.

## Timing
- Busy is registered. If busy is low in cycle t, the CPU may write or read in cycle t, and the RAM is never muxed away within cycle t.
- A CPU write in the cycle busy is low completes in that cycle.
- A CPU read takes:
  - 3 busy-low cycles, namely mem_read wait 0, 1, 2, then mem_fetch samples `cpu_rdata`;
  - the RAM returns data 1 cycle after the address is presented.
  - `CPU_WINDOW` >= 3 guarantees that the address is held and no scanout access intervenes.
- Scanout read latency: `vid_rdata` is valid in cycle t+1 for an ack in cycle t. Throughput is 1 word per cycle within a burst.
- Worst-case scanout wait for ownership: `CPU_WINDOW` cycles plus 1 cycle for the transition edge.
- Simultaneous `cpu_load` and `vid_req` at the window boundary: the CPU write in the current busy-low cycle is performed, and VID starts on the next cycle.
- `vid_req` dropping in VID: that cycle has no ack, and the arbiter returns to CPU on the next edge.
- `vid_req` must hold `vid_addr` stable until acked.

## Test plan
- Reset, idle:
  - Stimulus: assert `reset` 2 cycles with `vid_req` = 0.
  - Required: `cpu_busy` = 0, `vid_rvalid` = 0, `ram_we` = 0. A CPU write to 0x4005 data 0x1234 sets `ram_we` = 1 and `ram_addr` = 0x005 in that cycle.
- Burst cap:
  - Stimulus: hold `vid_req` high with addresses 0x000 onward.
  - Required: busy high for exactly 8 cycles, 8 acks, then busy low for exactly 3 cycles, then high again. `vid_rvalid` pulses lag acks by 1 cycle, with `vid_rdata` matching the preloaded RAM contents.
- Short burst:
  - Stimulus: `vid_req` high for 3 cycles, then low.
  - Required: 3 acks, busy returns low on the next edge, and the 3-cycle CPU window restarts.
- CPU read under contention:
  - Stimulus: CPU reads 0x4100 (RAM holds 0xBEEF) while the scanout streams continuously.
  - Required: the CPU captures 0xBEEF. `ram_addr` = 0x100 throughout the busy-low window, with no ack inside it.
- Non-VRAM write:
  - Stimulus: CPU `cpu_load` = 1 with address 0x2000 or 0x6000.
  - Required: `ram_we` = 0.
- Reset mid-burst:
  - Stimulus: reset during the 4th ack.
  - Required: next cycle busy = 0 and `vid_rvalid` = 0. After reset is released, the scanout regains ownership after 1 edge.
